pipe_hazard_ctrl: RTL

- Centralised, parametrised hazard and forwarding controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Replaces separate hazard-detection and forwarding units with one block producing stall, flush and bubble controls for every pipeline register.
- Adds N-operand forwarding, stage valid bits and a multi-cycle EX-op FSM (for M-extension mul/div) that freezes the front end until the op completes.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_if.sv | 55 +++++
 rtl/pipe_hazard_ctrl_fwd_select.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared types for the pipeline hazard/forwarding controller.
// Optional feature macro used by the top: HAZ_PERF_CNT_EN.
package pipe_hazard_ctrl_pkg;

   // Operand source selection for the EX-stage operand muxes.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,   // value captured in ID/EX
      FWD_WB  = 2'b01,   // write-back result
      FWD_MEM = 2'b10    // EX/MEM ALU result
   } fwd_sel_e;

   // Multi-cycle EX operation sequencer states.
   typedef enum logic [1:0] {
      MC_IDLE = 2'd0,
      MC_BUSY = 2'd1,
      MC_DONE = 2'd2
   } mc_state_e;

   localparam int FWD_SEL_W = 2;

   // A latency of one cycle means the op behaves like any single-cycle op.
   function automatic logic mc_enabled(input int lat);
      return (lat > 1);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline status in, pipeline-register controls out.
// master = pipeline datapath side, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
   parameter int NUM_SRC    = 2,
   parameter int RF_ADDRESS = 5
);
   // ID stage
   logic                          id_valid;
   logic [NUM_SRC*RF_ADDRESS-1:0] id_rs;
   logic [NUM_SRC-1:0]            id_rs_used;
   // EX stage
   logic                          ex_valid;
   logic                          ex_regwrite;
   logic                          ex_memread;
   logic                          ex_mc_op;
   logic [RF_ADDRESS-1:0]         ex_rd;
   logic [NUM_SRC*RF_ADDRESS-1:0] ex_rs;
   logic                          br_taken;
   // MEM stage
   logic                          mem_valid;
   logic                          mem_regwrite;
   logic [RF_ADDRESS-1:0]         mem_rd;
   // WB stage
   logic                          wb_valid;
   logic                          wb_regwrite;
   logic [RF_ADDRESS-1:0]         wb_rd;
   // Controls
   logic                          pc_stall;
   logic                          ifid_stall;
   logic                          ifid_flush;
   logic                          idex_stall;
   logic                          idex_bubble;
   logic                          exmem_bubble;
   logic [2*NUM_SRC-1:0]          fwd_sel;
   logic                          ex_busy;

   modport master (
      output id_valid, id_rs, id_rs_used,
      output ex_valid, ex_regwrite, ex_memread, ex_mc_op, ex_rd, ex_rs, br_taken,
      output mem_valid, mem_regwrite, mem_rd,
      output wb_valid, wb_regwrite, wb_rd,
      input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
      input  exmem_bubble, fwd_sel, ex_busy
   );

   modport slave (
      input  id_valid, id_rs, id_rs_used,
      input  ex_valid, ex_regwrite, ex_memread, ex_mc_op, ex_rd, ex_rs, br_taken,
      input  mem_valid, mem_regwrite, mem_rd,
      input  wb_valid, wb_regwrite, wb_rd,
      output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble,
      output exmem_bubble, fwd_sel, ex_busy
   );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// fwd_select: forwarding comparator chain for a single EX source operand.
module fwd_select
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int RF_ADDRESS = 5
)(
   input  logic [RF_ADDRESS-1:0] rs,
   input  logic                  mem_valid,
   input  logic                  mem_regwrite,
   input  logic [RF_ADDRESS-1:0] mem_rd,
   input  logic                  wb_valid,
   input  logic                  wb_regwrite,
   input  logic [RF_ADDRESS-1:0] wb_rd,
   output fwd_sel_e              sel
);

   logic mem_hit;
   logic wb_hit;

   // x0 is hard-wired zero, so a write to it never produces a forward.
   assign mem_hit = mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == rs);
   assign wb_hit  = wb_valid  && wb_regwrite  && (wb_rd  != '0) && (wb_rd  == rs);

   // The younger EX/MEM result shadows the older WB result.
   always_comb begin
      sel = FWD_RF;
      if (mem_hit) begin
         sel = FWD_MEM;
      end else if (wb_hit) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/bubble and forwarding control for the 5-stage pipeline.
// Optional macro HAZ_PERF_CNT_EN adds saturating load-use / multi-cycle / flush counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int RF_ADDRESS = 5,
   parameter int MC_LAT     = 4,
   parameter int CNT_W      = 16
)(
   input  logic              clk,
   input  logic              reset,
   pipe_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  perf_loaduse_cnt,
   output logic [CNT_W-1:0]  perf_mc_cnt,
   output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

   localparam logic             MC_EN   = mc_enabled(MC_LAT);
   localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'((MC_LAT > 1) ? (MC_LAT - 2) : 0);

   mc_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 mc_start;
   logic                 busy;
   logic                 load_use;
   logic [NUM_SRC-1:0]   lu_hit;
   fwd_sel_e             sel_w [NUM_SRC];
   logic [2*NUM_SRC-1:0] fwd_sel_w;
   logic                 pc_stall_w;
   logic                 ifid_stall_w;
   logic                 ifid_flush_w;
   logic                 idex_stall_w;
   logic                 idex_bubble_w;
   logic                 exmem_bubble_w;
   logic                 unused_sigs;

   // EX writeback intent is not needed: load-use is keyed on memread alone.
   assign unused_sigs = ^{1'b0, hz.ex_regwrite};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         logic [RF_ADDRESS-1:0] id_rs_k;
         logic [RF_ADDRESS-1:0] ex_rs_k;

         assign id_rs_k    = hz.id_rs[gi*RF_ADDRESS +: RF_ADDRESS];
         assign ex_rs_k    = hz.ex_rs[gi*RF_ADDRESS +: RF_ADDRESS];
         assign lu_hit[gi] = hz.id_rs_used[gi] && (id_rs_k == hz.ex_rd);

         fwd_select #(
            .RF_ADDRESS (RF_ADDRESS)
         ) u_fwd (
            .rs           (ex_rs_k),
            .mem_valid    (hz.mem_valid),
            .mem_regwrite (hz.mem_regwrite),
            .mem_rd       (hz.mem_rd),
            .wb_valid     (hz.wb_valid),
            .wb_regwrite  (hz.wb_regwrite),
            .wb_rd        (hz.wb_rd),
            .sel          (sel_w[gi])
         );
      end
   endgenerate

   // Pack per-operand selects; during reset every operand reads ID/EX.
   always_comb begin
      fwd_sel_w = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         fwd_sel_w[2*k +: 2] = reset ? FWD_RF : sel_w[k];
      end
   end

   // Busy is raised in the very cycle the op arrives so the front end freezes at once.
   assign mc_start = MC_EN && (state_q == MC_IDLE) && hz.ex_valid && hz.ex_mc_op;
   assign busy     = !reset && ((state_q == MC_BUSY) || mc_start);
   assign load_use = hz.id_valid && hz.ex_valid && hz.ex_memread &&
                     (hz.ex_rd != '0) && (|lu_hit);

   // Multi-cycle sequencer: arrival cycle + (MC_LAT-1) BUSY cycles, then DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         MC_IDLE: begin
            if (mc_start) begin
               state_d = MC_BUSY;
               cnt_d   = MC_LOAD;
            end
         end
         MC_BUSY: begin
            if (cnt_q == '0) begin
               state_d = MC_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         MC_DONE: begin
            state_d = MC_IDLE;
         end
         default: begin
            state_d = MC_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Sequencer state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MC_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Priority: reset, multi-cycle freeze, redirect, load-use.
   always_comb begin
      pc_stall_w     = 1'b0;
      ifid_stall_w   = 1'b0;
      ifid_flush_w   = 1'b0;
      idex_stall_w   = 1'b0;
      idex_bubble_w  = 1'b0;
      exmem_bubble_w = 1'b0;
      if (reset) begin
         // everything held low
      end else if (busy) begin
         // Keep the op in EX and send NOPs downstream until it completes.
         pc_stall_w     = 1'b1;
         ifid_stall_w   = 1'b1;
         idex_stall_w   = 1'b1;
         exmem_bubble_w = 1'b1;
      end else if (hz.br_taken) begin
         // Wrong-path instructions in IF/ID and ID are squashed; PC takes the target.
         ifid_flush_w  = 1'b1;
         idex_bubble_w = 1'b1;
      end else if (load_use) begin
         pc_stall_w    = 1'b1;
         ifid_stall_w  = 1'b1;
         idex_bubble_w = 1'b1;
      end
   end

   assign hz.pc_stall     = pc_stall_w;
   assign hz.ifid_stall   = ifid_stall_w;
   assign hz.ifid_flush   = ifid_flush_w;
   assign hz.idex_stall   = idex_stall_w;
   assign hz.idex_bubble  = idex_bubble_w;
   assign hz.exmem_bubble = exmem_bubble_w;
   assign hz.fwd_sel      = fwd_sel_w;
   assign hz.ex_busy      = busy;

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
   logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;
   logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;
   logic             lu_ev;

   // Only the load-use response raises pc_stall together with idex_bubble.
   assign lu_ev = pc_stall_w && idex_bubble_w;

   // Saturating event counters.
   always_comb begin
      lu_cnt_d = lu_cnt_q;
      mc_cnt_d = mc_cnt_q;
      fl_cnt_d = fl_cnt_q;
      if (lu_ev && (lu_cnt_q != '1)) begin
         lu_cnt_d = lu_cnt_q + 1'b1;
      end
      if (busy && (mc_cnt_q != '1)) begin
         mc_cnt_d = mc_cnt_q + 1'b1;
      end
      if (ifid_flush_w && (fl_cnt_q != '1)) begin
         fl_cnt_d = fl_cnt_q + 1'b1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         lu_cnt_q <= '0;
         mc_cnt_q <= '0;
         fl_cnt_q <= '0;
      end else begin
         lu_cnt_q <= lu_cnt_d;
         mc_cnt_q <= mc_cnt_d;
         fl_cnt_q <= fl_cnt_d;
      end
   end

   assign perf_loaduse_cnt = lu_cnt_q;
   assign perf_mc_cnt      = mc_cnt_q;
   assign perf_flush_cnt   = fl_cnt_q;
`endif

endmodule
